// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - core-side and memory-side signal bundle for mem_access_unit
//
// Core side:
//   req, wr, size, addr, wdata    request fields, driven by the core
//   rdata, done, busy, misalign   response, driven by the access unit
// Memory side:
//   mem_addr, mem_wr, mem_wdata   word-aligned access, driven by the access unit
//   mem_rdata                     read data, driven by the memory
// Modports:
//   master  core and memory side (drives requests and mem_rdata)
//   slave   the access unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              busy;
    logic              misalign;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req, wr, size, addr, wdata, mem_rdata,
        input  rdata, done, busy, misalign, mem_addr, mem_wr, mem_wdata
    );

    modport slave (
        input  req, wr, size, addr, wdata, mem_rdata,
        output rdata, done, busy, misalign, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - word/halfword/byte load-store adapter for a word-only memory
//
// Ports:
//   Clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mem_access_unit_if.slave (request/response and memory signals)
// Parameters:
//   MEM_LATENCY  cycles from mem_addr stable to mem_rdata valid (>= 1)
//   ADDR_W       byte address width
module mem_access_unit #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32
) (
    input  logic               Clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MEM_LATENCY - 1);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              req_err;
    logic              rd_last;

    // Selected lane of a memory word, zero-extended.
    function automatic logic [31:0] load_lane(input logic [1:0] sz, input logic [1:0] lane,
                                              input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        case (sz)
            SZ_BYTE: load_lane = {24'h0, sh[7:0]};
            SZ_HALF: load_lane = {16'h0, sh[15:0]};
            default: load_lane = w;
        endcase
    endfunction

    // Memory word with the target lane replaced by the low bits of the store data.
    function automatic logic [31:0] store_merge(input logic [1:0] sz, input logic [1:0] lane,
                                                input logic [31:0] w, input logic [31:0] d);
        logic [31:0] mask;
        logic [31:0] ins;
        if (sz == SZ_BYTE) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            ins  = {24'h0, d[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            ins  = {16'h0, d[15:0]} << {lane[1], 4'b0000};
        end
        store_merge = (w & ~mask) | ins;
    endfunction

    always_comb begin
        req_err = 1'b0;
        case (bus.size)
            SZ_WORD: req_err = (bus.addr[1:0] != 2'b00);
            SZ_HALF: req_err = bus.addr[0];
            SZ_BYTE: req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
    end

    assign rd_last = (state_q == RD) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    if (req_err)
                        state_d = DONE;
                    else if (bus.wr && (bus.size == SZ_WORD))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                if (rd_last)
                    state_d = wr_q ? WR : DONE;
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        wr_q    <= bus.wr;
                        size_q  <= bus.size;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        err_q   <= req_err;
                        cnt_q   <= CNT_RELOAD;
                    end
                end
                RD: begin
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - CNT_W'(1);
                    else if (wr_q)
                        merge_q <= store_merge(size_q, addr_q[1:0], bus.mem_rdata, wdata_q);
                    else
                        rdata_q <= load_lane(size_q, addr_q[1:0], bus.mem_rdata);
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from state so they drop the instant reset asserts.
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.misalign  = (state_q == DONE) && err_q;
    assign bus.mem_wr    = (state_q == WR);
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = (size_q == SZ_WORD) ? wdata_q : merge_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    logic Clk;
    logic reset;
    int   checks;
    int   errors;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.MEM_LATENCY(2), .ADDR_W(32)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Word memory with two-cycle read latency: one register stage after the address.
    logic [31:0] mem [0:63];
    logic [31:0] rd_d1;
    always @(posedge Clk) begin
        if (bus.mem_wr)
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        rd_d1 <= mem[bus.mem_addr[7:2]];
    end
    assign bus.mem_rdata = rd_d1;

    // Issues one request and observes until done (bounded); cycle numbers count from the acceptance edge.
    task automatic run_txn(input logic w, input logic [1:0] s, input logic [31:0] a,
                           input logic [31:0] d, output int done_cyc, output int wr_cyc,
                           output int wr_cnt, output logic [31:0] wr_addr,
                           output logic [31:0] wr_data, output logic mis);
        done_cyc = -1; wr_cyc = -1; wr_cnt = 0; wr_addr = 32'h0; wr_data = 32'h0; mis = 1'b0;
        @(negedge Clk);
        bus.req = 1'b1; bus.wr = w; bus.size = s; bus.addr = a; bus.wdata = d;
        @(posedge Clk);
        #1 bus.req = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge Clk);
            if (bus.mem_wr) begin
                wr_cnt++; wr_cyc = cyc; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata;
            end
            if (bus.done) begin
                done_cyc = cyc; mis = bus.misalign;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge Clk);
        checks++;
        if ({bus.done, bus.busy, bus.misalign, bus.mem_wr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b want 0000", {bus.done, bus.busy, bus.misalign, bus.mem_wr});
        end
        checks++;
        if ({bus.rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0", bus.rdata, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_word();
        int dc, wc, wn; logic [31:0] wa, wd; logic m;
        run_txn(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, dc, wc, wn, wa, wd, m);
        checks++;
        if (wc !== 1 || wn !== 1) begin
            errors++; $display("FAIL sw_wr_cycle got %0d (count %0d) want 1 (count 1)", wc, wn);
        end
        checks++;
        if (wa !== 32'h10 || wd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_wr_data got %h/%h want 00000010/deadbeef", wa, wd);
        end
        checks++;
        if (dc !== 2 || m !== 1'b0) begin
            errors++; $display("FAIL sw_done got cycle %0d mis %b want 2 mis 0", dc, m);
        end
        run_txn(1'b0, 2'b00, 32'h10, 32'h0, dc, wc, wn, wa, wd, m);
        checks++;
        if (dc !== 3 || wn !== 0) begin
            errors++; $display("FAIL lw_done got cycle %0d writes %0d want 3 writes 0", dc, wn);
        end
        checks++;
        if (bus.rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_rdata got %h want deadbeef", bus.rdata);
        end
    endtask

    task automatic test_subword_store();
        int dc, wc, wn; logic [31:0] wa, wd; logic m;
        run_txn(1'b1, 2'b01, 32'h15, 32'h000000AA, dc, wc, wn, wa, wd, m);
        checks++;
        if (wc !== 3 || wn !== 1) begin
            errors++; $display("FAIL sb_wr_cycle got %0d (count %0d) want 3 (count 1)", wc, wn);
        end
        checks++;
        if (wa !== 32'h14 || wd !== 32'h1122AA44) begin
            errors++; $display("FAIL sb_merge got %h/%h want 00000014/1122aa44", wa, wd);
        end
        checks++;
        if (dc !== 4) begin
            errors++; $display("FAIL sb_done got cycle %0d want 4", dc);
        end
        run_txn(1'b0, 2'b00, 32'h14, 32'h0, dc, wc, wn, wa, wd, m);
        checks++;
        if (bus.rdata !== 32'h1122AA44 || dc !== 3) begin
            errors++; $display("FAIL sb_readback got %h cycle %0d want 1122aa44 cycle 3", bus.rdata, dc);
        end
    endtask

    task automatic test_subword_load();
        int dc, wc, wn; logic [31:0] wa, wd; logic m;
        run_txn(1'b0, 2'b10, 32'h16, 32'hFFFFFFFF, dc, wc, wn, wa, wd, m);
        checks++;
        if (bus.rdata !== 32'h00001122 || dc !== 3) begin
            errors++; $display("FAIL lh_rdata got %h cycle %0d want 00001122 cycle 3", bus.rdata, dc);
        end
        run_txn(1'b0, 2'b01, 32'h17, 32'hFFFFFFFF, dc, wc, wn, wa, wd, m);
        checks++;
        if (bus.rdata !== 32'h00000011 || dc !== 3) begin
            errors++; $display("FAIL lb_rdata got %h cycle %0d want 00000011 cycle 3", bus.rdata, dc);
        end
    endtask

    task automatic test_misalign();
        int dc, wc, wn; logic [31:0] wa, wd; logic m;
        run_txn(1'b0, 2'b10, 32'h13, 32'h0, dc, wc, wn, wa, wd, m);
        checks++;
        if (dc !== 1 || m !== 1'b1 || wn !== 0) begin
            errors++; $display("FAIL mis_half got cycle %0d mis %b writes %0d want 1 1 0", dc, m, wn);
        end
        run_txn(1'b1, 2'b11, 32'h10, 32'h12345678, dc, wc, wn, wa, wd, m);
        checks++;
        if (dc !== 1 || m !== 1'b1 || wn !== 0) begin
            errors++; $display("FAIL mis_size11 got cycle %0d mis %b writes %0d want 1 1 0", dc, m, wn);
        end
        checks++;
        if (bus.rdata !== 32'h00000011) begin
            errors++; $display("FAIL mis_rdata_kept got %h want 00000011", bus.rdata);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL mis_mem_kept got %h want deadbeef", mem[4]);
        end
    endtask

    task automatic test_reset_abort();
        int dc, wc, wn; logic [31:0] wa, wd; logic m;
        @(negedge Clk);
        bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b01; bus.addr = 32'h15; bus.wdata = 32'h55;
        @(posedge Clk);
        #1 bus.req = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_before got %b want 1", bus.busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.mem_wr, bus.done, bus.misalign} !== 4'b0000) begin
            errors++; $display("FAIL abort_immediate got %b want 0000", {bus.busy, bus.mem_wr, bus.done, bus.misalign});
        end
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (mem[5] !== 32'h1122AA44 || bus.rdata !== 32'h0) begin
            errors++; $display("FAIL abort_mem got %h rdata %h want 1122aa44 rdata 0", mem[5], bus.rdata);
        end
        reset = 1'b1;
        run_txn(1'b0, 2'b00, 32'h14, 32'h0, dc, wc, wn, wa, wd, m);
        checks++;
        if (bus.rdata !== 32'h1122AA44 || dc !== 3 || wn !== 0) begin
            errors++; $display("FAIL abort_reload got %h cycle %0d writes %0d want 1122aa44 3 0", bus.rdata, dc, wn);
        end
    endtask

    task automatic test_back_to_back();
        int n_done, d1c, d2c;
        logic [31:0] r1, r2;
        logic addr_bad, busy4;
        n_done = 0; d1c = -1; d2c = -1; r1 = 32'h0; r2 = 32'h0; addr_bad = 1'b0; busy4 = 1'b1;
        @(negedge Clk);
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'b00; bus.addr = 32'h10; bus.wdata = 32'h0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge Clk);
            if (cyc == 1) bus.addr = 32'h14;
            if (cyc <= 3 && bus.mem_addr !== 32'h10) addr_bad = 1'b1;
            if (cyc == 4) busy4 = bus.busy;
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin d1c = cyc; r1 = bus.rdata; end
                else if (n_done == 2) begin d2c = cyc; r2 = bus.rdata; end
            end
            if (cyc == 5) bus.req = 1'b0;
        end
        checks++;
        if (addr_bad !== 1'b0) begin
            errors++; $display("FAIL b2b_addr_stable got changed want held at 00000010");
        end
        checks++;
        if (d1c !== 3 || r1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL b2b_first got cycle %0d data %h want 3 deadbeef", d1c, r1);
        end
        checks++;
        if (busy4 !== 1'b0 || d2c !== 7 || r2 !== 32'h1122AA44) begin
            errors++; $display("FAIL b2b_second got busy4 %b cycle %0d data %h want 0 7 1122aa44", busy4, d2c, r2);
        end
        checks++;
        if (n_done !== 2) begin
            errors++; $display("FAIL b2b_done_count got %0d want 2", n_done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[5] = 32'h11223344;
        reset = 1'b0;
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.addr = 32'h0; bus.wdata = 32'h0;
        repeat (2) @(posedge Clk);
        test_reset();
        reset = 1'b1;
        test_word();
        test_subword_store();
        test_subword_load();
        test_misalign();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
